// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_pkg : shared IF/ID constants, fetch word type and pointer helper
// Rev 1.0
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int              INS_W   = 32;
  localparam int              PC_W    = 30;
  localparam logic [INS_W-1:0] NOP_INS = '0;

  typedef struct packed {
    logic [INS_W-1:0] ins;
    logic [PC_W-1:0]  pc_plus_4;
  } if_word_t;

  // Modulo-DEPTH increment so non-power-of-two queues wrap correctly.
  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ins_ring_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ins_ring_fifo : ring-buffer storage with rd/wr pointers, count, push/pop/clear
// Rev 1.0
// ---------------------------------------------------------------------------
module ins_ring_fifo
  import pipe_pkg::*;
#(
  parameter int W     = 62,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Writes never land while full, even on a simultaneous pop.
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= AW'(wrap_inc(int'(wr_ptr), DEPTH));
      if (do_pop)  rd_ptr <= AW'(wrap_inc(int'(rd_ptr), DEPTH));
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_id_buffer : IF/ID boundary with instruction queue, bypass, flush and hold
// Rev 1.0
// ---------------------------------------------------------------------------
module if_id_buffer
  import pipe_pkg::*;
#(
  parameter int               INS_W   = pipe_pkg::INS_W,
  parameter int               PC_W    = pipe_pkg::PC_W,
  parameter int               DEPTH   = 4,
  parameter logic [INS_W-1:0] NOP_INS = pipe_pkg::NOP_INS
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       if_valid,
  input  logic [INS_W-1:0]           if_ins,
  input  logic [PC_W-1:0]            PC_plus_4,
  output logic                       if_ready,
  input  logic                       flush,
  input  logic                       hold,
  output logic [INS_W-1:0]           id_ins,
  output logic [PC_W-1:0]            id_PC_plus_4,
  output logic                       id_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int W = INS_W + PC_W;

  logic [W-1:0] head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         pop;
  logic         take;

  // Depends only on the registered count, so no input-to-output path.
  assign if_ready = !fifo_full;
  assign take     = if_valid && if_ready;

  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    if (!flush) begin
      if (hold) begin
        push = take;
      end else if (!fifo_empty) begin
        pop  = 1'b1;
        push = take;
      end
    end
  end

  ins_ring_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({if_ins, PC_plus_4}),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      id_ins       <= NOP_INS;
      id_PC_plus_4 <= '0;
      id_valid     <= 1'b0;
    end else if (flush) begin
      id_ins       <= NOP_INS;
      id_PC_plus_4 <= PC_plus_4;
      id_valid     <= 1'b0;
    end else if (!hold) begin
      if (!fifo_empty) begin
        {id_ins, id_PC_plus_4} <= head;
        id_valid               <= 1'b1;
      end else if (if_valid) begin
        // Empty queue: behave as a plain pipeline register.
        id_ins       <= if_ins;
        id_PC_plus_4 <= PC_plus_4;
        id_valid     <= 1'b1;
      end else begin
        id_ins   <= NOP_INS;
        id_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_if_id_buffer : scoreboard bench for if_id_buffer at DEPTH=4 and DEPTH=3
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_if_id_buffer;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        vld [2];
  logic        hld [2];
  logic        fl  [2];
  logic [31:0] ins_in;
  logic [29:0] pc_in;
  logic [31:0] o_ins [2];
  logic [29:0] o_pc  [2];
  logic        o_vld [2];
  logic        o_rdy [2];
  logic [2:0]  cnt4;
  logic [1:0]  cnt3;

  int total = 0;
  int bad   = 0;
  int sel   = 0;

  if_word_t    sb [$];
  logic [31:0] exp_ins;
  logic [29:0] exp_pc;
  logic        exp_vld;
  int          exp_cnt;

  if_id_buffer #(.DEPTH(4)) dut4 (
    .Clk(clk), .Rst(rst[0]), .if_valid(vld[0]), .if_ins(ins_in), .PC_plus_4(pc_in),
    .if_ready(o_rdy[0]), .flush(fl[0]), .hold(hld[0]), .id_ins(o_ins[0]),
    .id_PC_plus_4(o_pc[0]), .id_valid(o_vld[0]), .count(cnt4)
  );

  if_id_buffer #(.DEPTH(3)) dut3 (
    .Clk(clk), .Rst(rst[1]), .if_valid(vld[1]), .if_ins(ins_in), .PC_plus_4(pc_in),
    .if_ready(o_rdy[1]), .flush(fl[1]), .hold(hld[1]), .id_ins(o_ins[1]),
    .id_PC_plus_4(o_pc[1]), .id_valid(o_vld[1]), .count(cnt3)
  );

  function automatic int dep();
    return (sel == 1) ? 3 : 4;
  endfunction

  function automatic int cnt_of();
    return (sel == 1) ? int'(cnt3) : int'(cnt4);
  endfunction

  // Drive one cycle on the selected DUT and advance the reference model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [29:0] pc,
                      input logic h, input logic f, input logic r);
    if_word_t w;
    logic     acc;
    vld[sel] = v;  hld[sel] = h;  fl[sel] = f;  rst[sel] = r;
    ins_in   = ins; pc_in   = pc;
    acc = v && (sb.size() != dep());
    if (r) begin
      sb.delete();
      exp_ins = NOP_INS; exp_pc = '0; exp_vld = 1'b0;
    end else if (f) begin
      sb.delete();
      exp_ins = NOP_INS; exp_pc = pc; exp_vld = 1'b0;
    end else if (h) begin
      if (acc) sb.push_back('{ins: ins, pc_plus_4: pc});
    end else begin
      if (acc) sb.push_back('{ins: ins, pc_plus_4: pc});
      if (sb.size() > 0) begin
        w = sb.pop_front();
        exp_ins = w.ins; exp_pc = w.pc_plus_4; exp_vld = 1'b1;
      end else begin
        exp_ins = NOP_INS; exp_vld = 1'b0;
      end
    end
    exp_cnt = sb.size();
    @(posedge clk);
    #1;
    vld[sel] = 1'b0; hld[sel] = 1'b0; fl[sel] = 1'b0; rst[sel] = 1'b0;
  endtask

  task automatic test_reset();
    sel = 0;
    step(1'b1, 32'hFFFF_FFFF, 30'h3FF, 1'b0, 1'b0, 1'b1);
    total++;
    if (o_ins[0] !== 32'h0 || o_pc[0] !== 30'h0 || o_vld[0] !== 1'b0 || cnt4 !== 3'd0 || o_rdy[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset: got ins=%h pc=%h vld=%b cnt=%0d rdy=%b, want 0/0/0/0/1",
               o_ins[0], o_pc[0], o_vld[0], cnt4, o_rdy[0]);
    end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h1000 + i, 30'(i + 1), 1'b0, 1'b0, 1'b0);
      total++;
      if (o_ins[sel] !== exp_ins || o_pc[sel] !== exp_pc || o_vld[sel] !== exp_vld ||
          cnt_of() !== 0 || exp_ins !== 32'h1000 + i) begin
        bad++;
        $display("FAIL passthrough[%0d]: got ins=%h pc=%h vld=%b cnt=%0d, want ins=%h pc=%h vld=%b cnt=0",
                 i, o_ins[sel], o_pc[sel], o_vld[sel], cnt_of(), exp_ins, exp_pc, exp_vld);
      end
    end
  endtask

  task automatic test_hold_full();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h2000 + i, 30'(32'h100 + i), 1'b1, 1'b0, 1'b0);
      total++;
      if (o_ins[sel] !== exp_ins || o_vld[sel] !== exp_vld || cnt_of() !== exp_cnt ||
          o_rdy[sel] !== (exp_cnt != dep())) begin
        bad++;
        $display("FAIL hold[%0d]: got ins=%h vld=%b cnt=%0d rdy=%b, want ins=%h vld=%b cnt=%0d",
                 i, o_ins[sel], o_vld[sel], cnt_of(), o_rdy[sel], exp_ins, exp_vld, exp_cnt);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 30'h0, 1'b0, 1'b0, 1'b0);
      total++;
      if (o_ins[sel] !== exp_ins || o_pc[sel] !== exp_pc || o_vld[sel] !== exp_vld ||
          cnt_of() !== exp_cnt || o_rdy[sel] !== 1'b1) begin
        bad++;
        $display("FAIL release[%0d]: got ins=%h pc=%h vld=%b cnt=%0d rdy=%b, want ins=%h pc=%h vld=%b cnt=%0d",
                 i, o_ins[sel], o_pc[sel], o_vld[sel], cnt_of(), o_rdy[sel], exp_ins, exp_pc, exp_vld, exp_cnt);
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h3000 + i, 30'(32'h200 + i), 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 30'h155, 1'b0, 1'b1, 1'b0);
    total++;
    if (o_ins[sel] !== 32'h0 || o_vld[sel] !== 1'b0 || o_pc[sel] !== 30'h155 || cnt_of() !== 0) begin
      bad++;
      $display("FAIL flush: got ins=%h pc=%h vld=%b cnt=%0d, want ins=0 pc=155 vld=0 cnt=0",
               o_ins[sel], o_pc[sel], o_vld[sel], cnt_of());
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 30'h0, 1'b0, 1'b0, 1'b0);
      total++;
      if (o_ins[sel] !== exp_ins || o_vld[sel] !== 1'b0 || o_pc[sel] !== 30'h155 || cnt_of() !== 0) begin
        bad++;
        $display("FAIL after_flush[%0d]: got ins=%h pc=%h vld=%b cnt=%0d, want ins=%h pc=155 vld=0 cnt=0",
                 i, o_ins[sel], o_pc[sel], o_vld[sel], cnt_of(), exp_ins);
      end
    end
  endtask

  task automatic test_flush_hold();
    step(1'b1, 32'h4000, 30'h40, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h4001, 30'h41, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h4002, 30'h42, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h4003, 30'h2AA, 1'b1, 1'b1, 1'b0);
    total++;
    if (o_ins[sel] !== 32'h0 || o_vld[sel] !== 1'b0 || o_pc[sel] !== 30'h2AA || cnt_of() !== 0) begin
      bad++;
      $display("FAIL flush_hold: got ins=%h pc=%h vld=%b cnt=%0d, want ins=0 pc=2aa vld=0 cnt=0",
               o_ins[sel], o_pc[sel], o_vld[sel], cnt_of());
    end
  endtask

  task automatic test_back_to_back(input int which);
    sel = which;
    step(1'b0, 32'h0, 30'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < dep() - 1; i++) step(1'b1, 32'h6000 + i, 30'(32'h300 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2 * dep() + 1; i++) begin
      step(1'b1, 32'h7000 + i, 30'(32'h400 + i), 1'b0, 1'b0, 1'b0);
      total++;
      if (o_ins[sel] !== exp_ins || o_pc[sel] !== exp_pc || o_vld[sel] !== 1'b1 ||
          cnt_of() !== dep() - 1 || o_rdy[sel] !== 1'b1) begin
        bad++;
        $display("FAIL wrap_d%0d[%0d]: got ins=%h pc=%h vld=%b cnt=%0d, want ins=%h pc=%h vld=1 cnt=%0d",
                 dep(), i, o_ins[sel], o_pc[sel], o_vld[sel], cnt_of(), exp_ins, exp_pc, dep() - 1);
      end
    end
    for (int i = 0; i < dep(); i++) begin
      step(1'b0, 32'h0, 30'h0, 1'b0, 1'b0, 1'b0);
      total++;
      if (o_ins[sel] !== exp_ins || o_pc[sel] !== exp_pc || o_vld[sel] !== exp_vld || cnt_of() !== exp_cnt) begin
        bad++;
        $display("FAIL drain_d%0d[%0d]: got ins=%h pc=%h vld=%b cnt=%0d, want ins=%h pc=%h vld=%b cnt=%0d",
                 dep(), i, o_ins[sel], o_pc[sel], o_vld[sel], cnt_of(), exp_ins, exp_pc, exp_vld, exp_cnt);
      end
    end
  endtask

  task automatic test_rst_mid();
    sel = 0;
    step(1'b1, 32'h5000, 30'h50, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5001, 30'h51, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h5002, 30'h52, 1'b1, 1'b0, 1'b0);
    total++;
    if (o_ins[0] !== 32'h5000 || o_vld[0] !== 1'b1 || cnt4 !== 3'd2) begin
      bad++;
      $display("FAIL pre_rst: got ins=%h vld=%b cnt=%0d, want ins=5000 vld=1 cnt=2", o_ins[0], o_vld[0], cnt4);
    end
    step(1'b1, 32'h5003, 30'h53, 1'b0, 1'b0, 1'b1);
    total++;
    if (o_ins[0] !== 32'h0 || o_pc[0] !== 30'h0 || o_vld[0] !== 1'b0 || cnt4 !== 3'd0 || o_rdy[0] !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid: got ins=%h pc=%h vld=%b cnt=%0d rdy=%b, want 0/0/0/0/1",
               o_ins[0], o_pc[0], o_vld[0], cnt4, o_rdy[0]);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; vld[k] = 1'b0; hld[k] = 1'b0; fl[k] = 1'b0;
    end
    ins_in = '0;
    pc_in  = '0;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    test_reset();
    test_passthrough();
    test_hold_full();
    test_flush();
    test_flush_hold();
    test_back_to_back(1);
    test_back_to_back(0);
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
